// File: rtl/ysyx_22051013_mem_arb_pkg.sv
// Shared types for the IF/LSU memory arbiter: FSM state encoding and
// starvation counter sizing.
package ysyx_22051013_mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IF_ADDR = 3'd1,
    ST_IF_WAIT = 3'd2,
    ST_IF_DONE = 3'd3,
    ST_LS_ADDR = 3'd4,
    ST_LS_WAIT = 3'd5,
    ST_LS_DONE = 3'd6
  } state_t;

  // Wide enough for LS_MAX_CONSEC up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ysyx_22051013_arb_pick.sv
// Grant decision between a pending LSU access and a pending fetch, plus the
// next value of the LSU-consecutive-grant counter that guards IF starvation.
module ysyx_22051013_arb_pick
  import ysyx_22051013_mem_arb_pkg::*;
#(
  parameter int LS_MAX_CONSEC = 4
) (
  input  logic             ls_pend_i,
  input  logic             if_req_i,
  input  logic             if_flush_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             grant_ls_o,
  output logic             grant_if_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LS_MAX_CONSEC);

  logic if_starved;
  assign if_starved = if_req_i & (cnt_i == CNT_MAX);

  // NOTE: every output gets a default before the conditionals, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_ls_o = ls_pend_i & ~if_starved;
    grant_if_o = ~grant_ls_o & if_req_i & ~if_flush_i;
    cnt_o      = cnt_i;
    if (grant_ls_o) begin
      if (!if_req_i)              cnt_o = '0;
      else if (cnt_i >= CNT_MAX)  cnt_o = CNT_MAX;
      else                        cnt_o = cnt_i + 1'b1;
    end else if (grant_if_o) begin
      cnt_o = '0;
    end
  end

endmodule

// File: rtl/ysyx_22051013_mem_arb.sv
// Shares one memory request/response port between instruction fetch and the
// LSU; request fields are latched at grant so mem_* never follow the inputs.
module ysyx_22051013_mem_arb
  import ysyx_22051013_mem_arb_pkg::*;
#(
  parameter int LS_MAX_CONSEC = 4,
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_re,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wstrb,
  input  logic              ls_advance,
  output logic              ls_not_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_pick;
  logic              flush_q, flush_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [7:0]        req_wstrb_q, req_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_pend, grant_ls, grant_if;
  logic              unused_addr_bits;

  assign ls_pend          = ls_re | ls_we;
  assign unused_addr_bits = ^if_addr[2:0];

  ysyx_22051013_arb_pick #(
    .LS_MAX_CONSEC (LS_MAX_CONSEC)
  ) u_pick (
    .ls_pend_i  (ls_pend),
    .if_req_i   (if_req),
    .if_flush_i (if_flush),
    .cnt_i      (cnt_q),
    .grant_ls_o (grant_ls),
    .grant_if_o (grant_if),
    .cnt_o      (cnt_pick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_ls) begin
          // Both strobes high is illegal and resolves to a write.
          state_d     = ST_LS_ADDR;
          cnt_d       = cnt_pick;
          req_we_d    = ls_we;
          req_addr_d  = ls_addr;
          req_wdata_d = ls_we ? ls_wdata : '0;
          req_wstrb_d = ls_we ? ls_wstrb : '0;
        end else if (grant_if) begin
          state_d     = ST_IF_ADDR;
          cnt_d       = cnt_pick;
          req_we_d    = 1'b0;
          req_addr_d  = {if_addr[ADDR_W-1:3], 3'b000};
          req_wdata_d = '0;
          req_wstrb_d = '0;
        end
      end
      ST_IF_ADDR: begin
        flush_d = flush_q | if_flush;
        if (mem_ready) state_d = ST_IF_WAIT;
      end
      ST_IF_WAIT: begin
        flush_d = flush_q | if_flush;
        if (mem_rvalid) begin
          // The bus transfer always completes; a redirect only drops the pulse.
          if_rdata_d = mem_rdata;
          state_d    = (flush_q | if_flush) ? ST_IDLE : ST_IF_DONE;
        end
      end
      ST_IF_DONE: state_d = ST_IDLE;
      ST_LS_ADDR: if (mem_ready) state_d = ST_LS_WAIT;
      ST_LS_WAIT: begin
        if (mem_rvalid) begin
          if (!req_we_q) ls_rdata_d = mem_rdata;
          state_d = ST_LS_DONE;
        end
      end
      ST_LS_DONE: if (ls_advance) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) flush_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_valid = (state_q == ST_IF_ADDR) | (state_q == ST_LS_ADDR);
  assign mem_we    = req_we_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;
  assign mem_wstrb = req_wstrb_q;
  assign if_done   = (state_q == ST_IF_DONE);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

  // Gated by reset so the stall is also low while reset is held.
  assign ls_not_ready = rst & ls_pend & (state_q != ST_LS_DONE);

endmodule

// File: tb/tb_ysyx_22051013_mem_arb.sv
// Self-checking bench for the IF/LSU memory arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_ysyx_22051013_mem_arb;

  localparam int MAXC = 4;
  localparam logic [63:0] IF_A    = 64'h0000_0000_8000_100C;
  localparam logic [63:0] IF_A_AL = 64'h0000_0000_8000_1008;
  localparam logic [63:0] LS_B    = 64'h0000_0000_9000_0020;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 0, if_flush = 0, ls_re = 0, ls_we = 0, ls_advance = 0;
  logic [63:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [7:0]  ls_wstrb = 0;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic        if_done, ls_not_ready, mem_valid, mem_we;
  logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;

  int checks = 0, errors = 0;
  logic [63:0] exp_ls_rdata = 0, exp_if_rdata = 0;

  always #5 clk = ~clk;

  ysyx_22051013_mem_arb #(.LS_MAX_CONSEC(MAXC), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .ls_re(ls_re), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_advance(ls_advance),
    .ls_not_ready(ls_not_ready), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for a request, checks its fields stay put under back-pressure, accepts it.
  task automatic mem_accept(input int rdy_wait, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wstrb);
    int n;
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_valid_rise", 64'(mem_valid), 64'd1);
    check("ls_not_ready_busy", 64'(ls_not_ready), 64'(ls_re | ls_we));
    for (int i = 0; i <= rdy_wait; i++) begin
      check("mem_valid_held", 64'(mem_valid), 64'd1);
      check("mem_we", 64'(mem_we), 64'(we));
      check("mem_addr", mem_addr, addr);
      check("mem_wdata", mem_wdata, wdata);
      check("mem_wstrb", 64'(mem_wstrb), 64'(wstrb));
      mem_ready = (i == rdy_wait);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check("mem_valid_drop", 64'(mem_valid), 64'd0);
  endtask

  task automatic mem_respond(input int rv_wait, input logic [63:0] rdata);
    for (int i = 0; i < rv_wait; i++) begin
      check("mem_valid_in_wait", 64'(mem_valid), 64'd0);
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
  endtask

  task automatic ls_retire(input int hold, input logic drop);
    check("ls_not_ready_done", 64'(ls_not_ready), 64'd0);
    check("ls_rdata", ls_rdata, exp_ls_rdata);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ls_done_no_reissue", 64'(mem_valid), 64'd0);
      check("ls_not_ready_hold", 64'(ls_not_ready), 64'd0);
      check("ls_rdata_hold", ls_rdata, exp_ls_rdata);
    end
    ls_advance = 1'b1;
    if (drop) begin
      ls_re = 1'b0;
      ls_we = 1'b0;
    end
    @(negedge clk);
    ls_advance = 1'b0;
  endtask

  task automatic if_retire(input logic drop);
    check("if_done_pulse", 64'(if_done), 64'd1);
    check("if_rdata", if_rdata, exp_if_rdata);
    if (drop) if_req = 1'b0;
    @(negedge clk);
    check("if_done_one_cycle", 64'(if_done), 64'd0);
  endtask

  task automatic ls_txn(input logic re, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        input int rdy, input int rv, input int hold);
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    ls_re = re; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wstrb = strb;
    mem_accept(rdy, we, addr, we ? wdata : 64'd0, we ? strb : 8'd0);
    mem_respond(rv, rd);
    if (!we) exp_ls_rdata = rd;
    ls_retire(hold, 1'b1);
  endtask

  task automatic if_fetch(input logic [63:0] addr, input int rdy, input int rv);
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    if_req = 1'b1; if_addr = addr;
    mem_accept(rdy, 1'b0, addr & ~64'h7, 64'd0, 8'd0);
    mem_respond(rv, rd);
    exp_if_rdata = rd;
    if_retire(1'b1);
    check("if_rdata_held", if_rdata, exp_if_rdata);
  endtask

  // Both sides request continuously: every (MAXC+1)-th grant belongs to IF.
  task automatic contend(input int n);
    logic [63:0] rd;
    for (int k = 0; k < n; k++) begin
      rd = {$urandom, $urandom};
      if (k % (MAXC + 1) == MAXC) begin
        mem_accept($urandom_range(0, 2), 1'b0, IF_A_AL, 64'd0, 8'd0);
        mem_respond($urandom_range(0, 2), rd);
        exp_if_rdata = rd;
        if (k == n - 1) ls_re = 1'b0;
        if_retire(k == n - 1);
      end else begin
        mem_accept($urandom_range(0, 2), 1'b0, LS_B, 64'd0, 8'd0);
        mem_respond($urandom_range(0, 2), rd);
        exp_ls_rdata = rd;
        ls_retire(0, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic re, we;
    logic [63:0] a;

    // Reset state.
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_ls_rdata", ls_rdata, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst = 1'b1;

    // Single load, then the rdata must survive two stalled cycles.
    ls_txn(1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 2);
    check("load_value", ls_rdata, 64'h1122_3344_5566_7788 & 64'h0 | exp_ls_rdata);
    exp_ls_rdata = 64'h1122_3344_5566_7788;
    ls_re = 1'b1; ls_addr = 64'h0000_0000_8000_0010;
    mem_accept(0, 1'b0, 64'h0000_0000_8000_0010, 64'd0, 8'd0);
    mem_respond(0, 64'h1122_3344_5566_7788);
    ls_retire(2, 1'b1);

    // Store with three cycles of back-pressure and a held LS_DONE.
    ls_txn(1'b0, 1'b1, 64'h0000_0000_8000_0040, {$urandom, $urandom}, 8'h0F, 3, 1, 2);
    check("store_keeps_ls_rdata", ls_rdata, 64'h1122_3344_5566_7788);

    // Fetch alignment.
    if_fetch(64'h0000_0000_8000_0004, 0, 0);

    // Flush during IF_WAIT: response consumed, no pulse, next fetch normal.
    if_req = 1'b1; if_addr = IF_A;
    mem_accept(1, 1'b0, IF_A_AL, 64'd0, 8'd0);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    mem_respond(1, {$urandom, $urandom});
    check("flush_no_done", 64'(if_done), 64'd0);
    @(negedge clk);
    check("flush_no_done_2", 64'(if_done), 64'd0);
    check("flush_idle", 64'(mem_valid), 64'd0);
    if_fetch(64'h0000_0000_8000_2006, 0, 1);

    // Stray response while idle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_ls_rdata", ls_rdata, exp_ls_rdata);
    check("stray_if_rdata", if_rdata, exp_if_rdata);
    check("stray_no_done", 64'(if_done), 64'd0);

    // Starvation bound under continuous contention.
    ls_wdata = 64'hA5A5_A5A5_A5A5_A5A5; ls_wstrb = 8'hFF;
    if_req = 1'b1; if_addr = IF_A; ls_re = 1'b1; ls_addr = LS_B;
    contend(2 * (MAXC + 1));

    // Reset during LS_WAIT with a partly advanced counter.
    if_req = 1'b1; ls_re = 1'b1;
    contend(2);
    mem_accept(0, 1'b0, LS_B, 64'd0, 8'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_mem_valid", 64'(mem_valid), 64'd0);
    check("arst_mem_we", 64'(mem_we), 64'd0);
    check("arst_mem_addr", mem_addr, 64'd0);
    check("arst_mem_wdata", mem_wdata, 64'd0);
    check("arst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("arst_if_done", 64'(if_done), 64'd0);
    check("arst_if_rdata", if_rdata, 64'd0);
    check("arst_ls_rdata", ls_rdata, 64'd0);
    check("arst_ls_not_ready", 64'(ls_not_ready), 64'd0);
    exp_ls_rdata = 64'd0; exp_if_rdata = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    contend(MAXC + 1);

    // Randomized LSU traffic; both strobes high behaves as a store.
    for (int t = 0; t < 10; t++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (!re && !we) re = 1'b1;
      a = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)};
      ls_txn(re, we, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2));
    end
    check("if_rdata_untouched_by_lsu", if_rdata, exp_if_rdata);

    // Randomized fetches.
    for (int t = 0; t < 4; t++) begin
      if_fetch({32'h0, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_mem_arb.md
Name: ysyx_22051013_mem_arb

Overview:
Arbiter and sequencer that shares one memory request/response port between instruction fetch (IF) and the load/store unit (LSU). Drives the LSU's data_not_ready stall and returns load data. Returns fetch data with a one-cycle done pulse. Sits between the pipeline (IFU, LSU) and the AXI bridge.

Parameters:
LS_MAX_CONSEC, 4, consecutive LSU grants allowed while IF is pending before IF is forced one grant (range 1..15)
ADDR_W, 64, address width
DATA_W, 64, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (rst==0 resets)
if_req  in  1  fetch request, level, held until if_done or if_flush
if_addr  in  ADDR_W  fetch address; bits [2:0] dropped on issue
if_flush  in  1  redirect; discard the in-flight/pending fetch result
if_done  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  registered fetch data, held until next fetch response
ls_re  in  1  LSU load request (level)
ls_we  in  1  LSU store request (level)
ls_addr  in  ADDR_W  LSU address, passed unmodified
ls_wdata  in  DATA_W  store data
ls_wstrb  in  8  store byte mask
ls_advance  in  1  LSU stage instruction leaves the stage this cycle
ls_not_ready  out  1  LSU stall: (ls_re|ls_we) & ~(state==LS_DONE)
ls_rdata  out  DATA_W  registered load data, held until next LSU response
mem_valid  out  1  request valid
mem_ready  in  1  request accepted when mem_valid&mem_ready
mem_we  out  1  1=write
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data (0 for reads)
mem_wstrb  out  8  write mask (0 for reads)
mem_rvalid  in  1  response (read data or write ack), always accepted
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; if_rdata/ls_rdata 0; starvation counter 0; flush flag 0.
- States: IDLE, IF_ADDR, IF_WAIT, IF_DONE, LS_ADDR, LS_WAIT, LS_DONE.
- IDLE grant: ls_pend=ls_re|ls_we. If ls_pend and not (if_req & cnt==LS_MAX_CONSEC) -> LS_ADDR; else if if_req & ~if_flush -> IF_ADDR; else stay.
- Counter: +1 on each LSU grant with if_req high (saturate at LS_MAX_CONSEC); cleared on IF grant or when if_req low at LSU grant.
- Request address/data latched on grant; mem_* driven from latches, stable while mem_valid=1 (no combinational path from inputs to mem_*).
- IF_ADDR: mem_valid=1, mem_we=0, mem_addr={if_addr[63:3],3'b000}; on mem_ready -> IF_WAIT.
- IF_WAIT: on mem_rvalid capture if_rdata -> IF_DONE, or -> IDLE if flush flag set.
- IF_DONE: if_done=1 for exactly one cycle -> IDLE.
- Flush flag: set when if_flush seen in IF_ADDR/IF_WAIT; cleared on return to IDLE. The memory transaction is never aborted mid-flight; only if_done is suppressed. if_flush in IF_DONE has no effect on that pulse's delivery (IFU discards).
- LS_ADDR: mem_valid=1, mem_we=ls_we, mem_wdata/mem_wstrb = store values on write, 0 on read; on mem_ready -> LS_WAIT.
- LS_WAIT: on mem_rvalid, if read capture ls_rdata; -> LS_DONE.
- LS_DONE: ls_not_ready=0; hold until ls_advance=1 -> IDLE. Prevents re-issue of the same access while WB back-pressures.
- ls_re & ls_we both 1: illegal; treated as write.
- ls_re/ls_we dropping during LS_ADDR/LS_WAIT: transaction completes; result discarded.
- mem_rvalid outside *_WAIT: ignored.
- Minimum latency: grant->done = 3 cycles with mem_ready and mem_rvalid each 1 cycle after assertion.

Decomposition:
- Shared define file: state encodings (3-bit), ysyx_22051013_ZERO64, RSTABLE-style active-low reset macro.
- One sub-module natural: ysyx_22051013_arb_pick (combinational grant + starvation counter compare); the FSM stays in top.

Test Plan:
- Single load: ls_re=1, addr 0x80000010, mem_ready/mem_rvalid 1 cycle later, rdata 0x1122334455667788 -> mem_addr 0x80000010, mem_we=0, ls_not_ready low from LS_DONE, ls_rdata 0x1122334455667788, held until ls_advance.
- Store with back-pressure: ls_we=1, wstrb 0x0F, mem_ready low 3 cycles -> mem_* stable 4 cycles; mem_wstrb 0x0F; LS_DONE held 2 cycles with ls_advance=0, no second mem_valid.
- Simultaneous: if_req and ls_re continuously -> grant order LS x4, IF, LS x4, IF (LS_MAX_CONSEC=4).
- Fetch alignment: if_addr 0x80000004 -> mem_addr 0x80000000; if_done one pulse; if_rdata = mem_rdata.
- Flush: if_flush during IF_WAIT -> response consumed, no if_done, next grant proceeds normally.
- Reset mid-LS_WAIT: rst low -> all outputs 0 immediately (async); after release state IDLE, counter 0.
